// File: rtl/mxalu11_pkg.sv
// Shared types and constants for the mxalu11 ALU sequencing stage.
package mxalu11_pkg;

    localparam int unsigned MXALU11_W  = 8;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/mxalu11_settle_cnt.sv
// Settle-window down-counter: load, decrement toward zero, zero-detect.
module mxalu11_settle_cnt
    import mxalu11_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a load wins, otherwise decrement and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mxalu11_ctl.sv
// ALU sequencing stage: drives a 181-style ALU, waits out the settle window,
// captures result and flags into the accumulator, then offers the result.
module mxalu11_ctl
    import mxalu11_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_opcode,
    input  logic [MXALU11_W-1:0] in_src,
    input  logic                 in_load,
    output logic [3:0]           alu_opcode,
    output logic [MXALU11_W-1:0] alu_a,
    output logic [MXALU11_W-1:0] alu_b,
    output logic                 alu_cs_n,
    input  logic [MXALU11_W-1:0] alu_f,
    input  logic                 alu_cn8_n,
    input  logic                 alu_a_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MXALU11_W-1:0] acc,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_eq
);

    state_e               state_q;
    logic [3:0]           alu_opcode_q;
    logic [MXALU11_W-1:0] alu_a_q;
    logic [MXALU11_W-1:0] alu_b_q;
    logic                 alu_cs_n_q;
    logic [MXALU11_W-1:0] acc_q;
    logic                 flag_c_q;
    logic                 flag_z_q;
    logic                 flag_eq_q;

    logic accept;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign cnt_load = accept && !in_load;
    assign cnt_dec  = (state_q == DRIVE) && !cnt_zero;

    mxalu11_settle_cnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(SETTLE - 1)),
        .dec_i      (cnt_dec),
        .zero_c     (cnt_zero)
    );

    // Sequencing FSM with the ALU input, accumulator and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cs_n_q   <= 1'b1;
            acc_q        <= '0;
            flag_c_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_eq_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (in_load) begin
                            acc_q    <= in_src;
                            flag_z_q <= (in_src == '0);
                            state_q  <= RESULT;
                        end else begin
                            alu_opcode_q <= in_opcode;
                            alu_a_q      <= acc_q;
                            alu_b_q      <= in_src;
                            alu_cs_n_q   <= 1'b0;
                            state_q      <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_zero) begin
                        acc_q      <= alu_f;
                        flag_c_q   <= ~alu_cn8_n;
                        flag_z_q   <= (alu_f == '0);
                        flag_eq_q  <= alu_a_b;
                        alu_cs_n_q <= 1'b1;
                        state_q    <= RESULT;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = (state_q == RESULT);
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cs_n   = alu_cs_n_q;
    assign acc        = acc_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;
    assign flag_eq    = flag_eq_q;

endmodule
